// File: rtl/msg_pkg.sv
// Shared widths, character codes and the 7-segment glyph table
// for the scrolling-message display path.
package msg_pkg;

    localparam int MSG_CHARS = 8;
    localparam int CH_W      = 5;
    localparam int MSG_W     = MSG_CHARS * CH_W;

    localparam logic [CH_W-1:0] CH_BLANK  = 5'd0;
    localparam logic [CH_W-1:0] CH_A      = 5'd1;
    localparam logic [CH_W-1:0] CH_B      = 5'd2;
    localparam logic [CH_W-1:0] CH_C      = 5'd3;
    localparam logic [CH_W-1:0] CH_D      = 5'd4;
    localparam logic [CH_W-1:0] CH_E      = 5'd5;
    localparam logic [CH_W-1:0] CH_F      = 5'd6;
    localparam logic [CH_W-1:0] CH_G      = 5'd7;
    localparam logic [CH_W-1:0] CH_H      = 5'd8;
    localparam logic [CH_W-1:0] CH_I      = 5'd9;
    localparam logic [CH_W-1:0] CH_J      = 5'd10;
    localparam logic [CH_W-1:0] CH_K      = 5'd11;
    localparam logic [CH_W-1:0] CH_L      = 5'd12;
    localparam logic [CH_W-1:0] CH_M      = 5'd13;
    localparam logic [CH_W-1:0] CH_N      = 5'd14;
    localparam logic [CH_W-1:0] CH_O      = 5'd15;
    localparam logic [CH_W-1:0] CH_P      = 5'd16;
    localparam logic [CH_W-1:0] CH_Q      = 5'd17;
    localparam logic [CH_W-1:0] CH_R      = 5'd18;
    localparam logic [CH_W-1:0] CH_S      = 5'd19;
    localparam logic [CH_W-1:0] CH_T      = 5'd20;
    localparam logic [CH_W-1:0] CH_U      = 5'd21;
    localparam logic [CH_W-1:0] CH_V      = 5'd22;
    localparam logic [CH_W-1:0] CH_W_CHAR = 5'd23;
    localparam logic [CH_W-1:0] CH_X      = 5'd24;
    localparam logic [CH_W-1:0] CH_Y      = 5'd25;
    localparam logic [CH_W-1:0] CH_Z      = 5'd26;
    localparam logic [CH_W-1:0] CH_DASH   = 5'd27;
    localparam logic [CH_W-1:0] CH_USCORE = 5'd28;

    // Active-high {g,f,e,d,c,b,a}; codes 29..31 render blank
    localparam logic [6:0] MSG_GLYPH [32] = '{
        7'h00, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D,
        7'h76, 7'h06, 7'h1E, 7'h75, 7'h38, 7'h15, 7'h54, 7'h3F,
        7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A,
        7'h76, 7'h6E, 7'h5B, 7'h40, 7'h08, 7'h00, 7'h00, 7'h00
    };

endpackage

// File: rtl/msg_glyph_rom.sv
// Combinational 5-bit character code to 7-segment glyph lookup.
module msg_glyph_rom
    import msg_pkg::*;
(
    input  logic [CH_W-1:0] code,
    output logic [6:0]      glyph
);

    assign glyph = MSG_GLYPH[code];

endmodule

// File: rtl/msg_scan_display.sv
// 8-digit multiplexed 7-segment scanner with per-frame message snapshot.
// Optional blink gating is enabled by defining MSG_SCAN_BLINK_EN.
module msg_scan_display
    import msg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSG_W-1:0]     instruction,
    input  logic                 blink,
    output logic [MSG_CHARS-1:0] an,
    output logic [6:0]           seg,
    output logic                 frame_start
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
    localparam logic [MSG_CHARS-1:0] AN_OFF =
        (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0] SEG_OFF =
        (ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]     div_cnt;
    logic [2:0]           digit;
    logic [MSG_W-1:0]     shadow;
    logic [CH_W-1:0]      cur_code;
    logic [6:0]           cur_glyph;
    logic                 slot_end;
    logic                 frame_edge;
    logic                 frame_end;
    logic                 blank_out;
    logic [MSG_CHARS-1:0] an_d;
    logic [6:0]           seg_d;

    assign slot_end   = (div_cnt == DIV_LAST);
    assign frame_edge = (digit == 3'd0) && (div_cnt == '0);
    assign frame_end  = slot_end && (digit == 3'd7);
    assign cur_code   = shadow[CH_W*digit +: CH_W];

    msg_glyph_rom u_rom (
        .code  (cur_code),
        .glyph (cur_glyph)
    );

    // Snapshot lands in a guard cycle, so a lit glyph never changes mid-slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            digit       <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= slot_end ? '0 : div_cnt + DIV_W'(1);
            if (slot_end)
                digit <= digit + 3'd1;
            if (frame_edge)
                shadow <= instruction;
            frame_start <= frame_edge;
        end
    end

`ifdef MSG_SCAN_BLINK_EN
    localparam int FR_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt;
    logic            phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FR_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    assign blank_out = blink && phase;
`else
    logic unused_blink;
    logic unused_frame_end;

    assign unused_blink     = blink ^ (BLINK_FRAMES > 0);
    assign unused_frame_end = frame_end;
    assign blank_out        = 1'b0;
`endif

    always_comb begin
        an_d  = '0;
        seg_d = '0;
        if (div_cnt >= GUARD_V && !blank_out) begin
            an_d  = MSG_CHARS'(1) << digit;
            seg_d = cur_glyph;
        end
    end

    // XOR with the off pattern folds in the board polarity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_d ^ AN_OFF;
            seg <= seg_d ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_msg_scan_display.sv
// Scoreboard bench for msg_scan_display: cycle-indexed reference model,
// directed and random messages, async mid-frame reset, optional blink.
module tb_msg_scan_display;

    localparam int RD    = 4;
    localparam int GD    = 1;
    localparam int BF    = 2;
    localparam int FRAME = 8 * RD;

    localparam logic [39:0] M1 =
        {5'd9, 5'd14, 5'd16, 5'd21, 5'd20, 5'd0, 5'd1, 5'd14};
    localparam logic [39:0] M2 =
        {5'd20, 5'd21, 5'd16, 5'd14, 5'd9, 5'd1, 5'd0, 5'd27};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blink = 1'b0;
    logic [39:0] instruction = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    msg_scan_display #(
        .REFRESH_DIV  (RD),
        .GUARD        (GD),
        .ACTIVE_LOW   (0),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .blink       (blink),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
        int         cyc;
    } exp_t;

    exp_t        expq[$];
    logic [39:0] frame_msg[$];
    int          checks = 0;
    int          errors = 0;
    int          tcyc = 0;
    bit          blink_on = 1'b0;
    int          codes[12] = '{0, 1, 9, 14, 16, 20, 21, 27, 28, 29, 30, 31};

    function automatic logic [6:0] ref_glyph(logic [4:0] c);
        case (c)
            5'd1:    return 7'b1110111;
            5'd9:    return 7'b0000110;
            5'd14:   return 7'b1010100;
            5'd16:   return 7'b1110011;
            5'd20:   return 7'b1111000;
            5'd21:   return 7'b0111110;
            5'd27:   return 7'b1000000;
            5'd28:   return 7'b0001000;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [39:0] rand_msg();
        logic [39:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            m[5*i +: 5] = 5'(codes[$urandom_range(0, 11)]);
        return m;
    endfunction

    function automatic logic [39:0] directed(int k);
        logic [39:0] m;
        int f;
        if (k < 2*FRAME + 3*RD + 2)
            return M1;
        m = M2;
        f = k / FRAME;
        if (f == 4)
            m[4:0] = 5'd27;
        else if (f == 5)
            m[4:0] = 5'd28;
        else if (f >= 6)
            m[4:0] = 5'd31;
        return m;
    endfunction

    // Outputs in cycle t reflect counter position kk = t-2 since reset
    function automatic exp_t predict(int kk, int t);
        exp_t e;
        int div, dig, f;
        e.an = '0;
        e.seg = '0;
        e.fs = 1'b0;
        e.cyc = t;
        if (kk < 0)
            return e;
        e.fs = (kk % FRAME == 0);
        div = kk % RD;
        dig = (kk / RD) % 8;
        f = kk / FRAME;
        if (div >= GD && !(blink_on && ((f / BF) % 2 == 1))) begin
            e.an = 8'(1) << dig;
            e.seg = ref_glyph(frame_msg[f][5*dig +: 5]);
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    task automatic run(int ncyc, int mode);
        logic [39:0] v;
        int k;
        for (int n = 0; n < ncyc; n++) begin
            tcyc++;
            k = tcyc - 1;
            v = instruction;
            if (mode == 0)
                v = directed(k);
            else if ($urandom_range(0, 7) == 0)
                v = rand_msg();
            instruction = v;
            if (k % FRAME == 0)
                frame_msg.push_back(v);
            expq.push_back(predict(tcyc - 2, tcyc));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        blink = blink_on;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_an", 32'(an), 32'h0);
        chk("reset_seg", 32'(seg), 32'h0);
        chk("reset_fs", 32'(frame_start), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tcyc = 0;
        frame_msg.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (an !== e.an || seg !== e.seg || frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL scan cyc %0d: got an=%h seg=%b fs=%b, expected an=%h seg=%b fs=%b",
                             e.cyc, an, seg, frame_start, e.an, e.seg, e.fs);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        hold_reset();
        run(7 * FRAME, 0);
        run(20 * FRAME, 1);
        run(5 * RD + 2, 1);
        chk("pre_rst_an", 32'(an), 32'h20);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'h0);
        chk("async_rst_seg", 32'(seg), 32'h0);
        chk("async_rst_fs", 32'(frame_start), 32'h0);
        hold_reset();
        run(4 * FRAME, 1);
`ifdef MSG_SCAN_BLINK_EN
        blink_on = 1'b1;
        hold_reset();
        run(6 * FRAME, 1);
        blink_on = 1'b0;
        hold_reset();
        run(6 * FRAME, 1);
`endif
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
